uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Request/FIFO-side bundle for uart_tx_arbiter: four byte requesters sharing one TX FIFO write port.
// master = requester/FIFO environment, slave = the arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of four byte requesters exclusive use of the TX FIFO write port,
// with release on end-of-packet, burst limit, or idle timeout of the owner.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus,
  output logic                grant_valid,
  output logic [1:0]          grant_id,
  output logic                timeout_pulse
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_last_id;
  logic [1:0]  r_grant_id;
  logic [8:0]  r_burst;
  logic [15:0] r_stall;
  logic        r_grant_valid;
  logic        r_timeout;

  logic [1:0]  w_pick;
  logic [1:0]  w_idx;
  logic        w_any;
  logic        w_own;
  logic        w_own_valid;
  logic        w_own_last;
  logic [7:0]  w_own_data;
  logic        w_xfer;
  logic [8:0]  w_burst_next;
  logic        w_burst_done;
  logic        w_stall_cyc;
  logic        w_timeout;

  // Scan upward starting one past the previous owner so every waiting requester gets a turn.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_last_id + 2'(k + 1);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  assign w_own        = (r_state == S_OWN);
  assign w_own_valid  = bus.req_valid[r_grant_id];
  assign w_own_last   = bus.req_last[r_grant_id];
  assign w_own_data   = bus.req_data[{r_grant_id, 3'b000} +: 8];
  assign w_xfer       = w_own & w_own_valid & ~bus.fifo_full;
  assign w_burst_next = r_burst + 9'd1;
  assign w_burst_done = (w_burst_next == 9'(MAX_BURST));
  assign w_stall_cyc  = w_own & ~w_own_valid;
  assign w_timeout    = w_stall_cyc && (r_stall == 16'(IDLE_TIMEOUT - 1));

  // Ready is combinational on fifo_full so a full FIFO blocks the write in the same cycle.
  assign bus.req_ready    = (w_own && !bus.fifo_full) ? (4'b0001 << r_grant_id) : '0;
  assign bus.fifo_wr_en   = w_xfer;
  assign bus.fifo_wr_data = w_xfer ? w_own_data : '0;

  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;
  assign timeout_pulse = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_id     <= 2'd3;
      r_grant_id    <= '0;
      r_burst       <= '0;
      r_stall       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state       <= S_OWN;
            r_grant_id    <= w_pick;
            r_grant_valid <= 1'b1;
            r_burst       <= '0;
            r_stall       <= '0;
          end
        end
        S_OWN: begin
          // A transfer always wins over a stall, so last-byte and timeout never coincide.
          if (w_xfer) begin
            r_stall <= '0;
            if (w_own_last || w_burst_done) begin
              r_state       <= S_IDLE;
              r_last_id     <= r_grant_id;
              r_grant_valid <= 1'b0;
              r_burst       <= '0;
            end else begin
              r_burst <= w_burst_next;
            end
          end else if (w_stall_cyc) begin
            if (w_timeout) begin
              r_state       <= S_IDLE;
              r_last_id     <= r_grant_id;
              r_grant_valid <= 1'b0;
              r_timeout     <= 1'b1;
              r_stall       <= '0;
              r_burst       <= '0;
            end else begin
              r_stall <= r_stall + 16'd1;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
